// File: rtl/rr_trace_packer.sv
// Packs variable-length logging units into contiguous OUT_WIDTH beats.
// Optional: define RR_PACKER_LEN_CHECK_EN to recompute lengths from the bitmap and flag mismatches.

package rr_trace_packer_pkg;
  function automatic int sum_widths(input logic [1023:0] flat, input int cnt, input int wbits);
    logic [1023:0] tmp;
    int            s;
    tmp = flat;
    s   = 0;
    for (int i = 0; i < cnt; i++) begin
      for (int b = 0; b < wbits; b++) begin
        if (tmp[0]) s = s + (1 << b);
        tmp = tmp >> 1;
      end
    end
    return s;
  endfunction
endpackage

module rr_trace_packer #(
  parameter int LOGB_CHANNEL_CNT      = 2,
  parameter int LOGE_CHANNEL_CNT      = 1,
  parameter int RR_CHANNEL_WIDTH_BITS = 16,
  parameter logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] CHANNEL_WIDTHS = {16'd200, 16'd100},
  parameter int OUT_WIDTH             = 512,
  parameter int CNT_WIDTH             = 32,
  localparam int FULL_WIDTH   = rr_trace_packer_pkg::sum_widths(1024'(CHANNEL_WIDTHS), LOGB_CHANNEL_CNT,
                                  RR_CHANNEL_WIDTH_BITS) + LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT,
  localparam int OFFSET_WIDTH = $clog2(FULL_WIDTH + 1),
  localparam int FILL_WIDTH   = $clog2(2 * OUT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    sync_rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FULL_WIDTH-1:0]   in_data,
  input  logic [OFFSET_WIDTH-1:0] in_len,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_WIDTH-1:0]    out_data,
  output logic                    out_last,
  output logic                    flush_done,
  output logic [CNT_WIDTH-1:0]    unit_cnt,
  output logic [CNT_WIDTH-1:0]    beat_cnt,
  output logic                    len_err
);

  localparam int ACC_W = 2 * OUT_WIDTH;
  localparam logic [FILL_WIDTH-1:0] OUT_W_F = FILL_WIDTH'(OUT_WIDTH);

  if (FULL_WIDTH > OUT_WIDTH) begin : g_width_check
    $error("rr_trace_packer: FULL_WIDTH %0d exceeds OUT_WIDTH %0d", FULL_WIDTH, OUT_WIDTH);
  end

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [FILL_WIDTH-1:0]   fill_q, fill_d;
  logic [CNT_WIDTH-1:0]    unit_cnt_q, beat_cnt_q;

  logic                    in_hs, out_hs;
  logic [OFFSET_WIDTH-1:0] eff_len;
  logic [FULL_WIDTH-1:0]   unit_masked;
  logic [ACC_W-1:0]        acc_base;
  logic [FILL_WIDTH-1:0]   fill_base;

  // Valid/ready: a transfer happens on a rising edge where both are high;
  // both handshake outputs depend only on registered state, never on the partner's signal.
  assign in_ready   = (state_q == S_RUN) && (fill_q < OUT_W_F);
  assign out_valid  = (fill_q >= OUT_W_F) || ((state_q == S_FLUSH) && (fill_q != '0));
  assign out_data   = acc_q[OUT_WIDTH-1:0];
  assign out_last   = out_valid && (state_q == S_FLUSH) && (fill_q <= OUT_W_F);
  assign flush_done = (state_q == S_DONE);
  assign unit_cnt   = unit_cnt_q;
  assign beat_cnt   = beat_cnt_q;

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

`ifdef RR_PACKER_LEN_CHECK_EN
  logic [OFFSET_WIDTH-1:0] calc_len;
  logic                    len_err_q;

  always_comb begin
    logic [LOGB_CHANNEL_CNT-1:0]                            bm;
    logic [LOGB_CHANNEL_CNT-1:0][RR_CHANNEL_WIDTH_BITS-1:0] cw;
    bm       = in_data[LOGB_CHANNEL_CNT-1:0];
    cw       = CHANNEL_WIDTHS;
    calc_len = OFFSET_WIDTH'(LOGB_CHANNEL_CNT + LOGE_CHANNEL_CNT);
    for (int i = 0; i < LOGB_CHANNEL_CNT; i++) begin
      if (bm[0]) calc_len = calc_len + OFFSET_WIDTH'(cw[0]);
      bm = bm >> 1;
      cw = cw >> RR_CHANNEL_WIDTH_BITS;
    end
  end

  // The bitmap-derived length is authoritative; a disagreeing in_len only raises the flag.
  assign eff_len = calc_len;
  assign len_err = len_err_q;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      len_err_q <= 1'b0;
    end else if (in_hs && (in_len != calc_len)) begin
      len_err_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!sync_rst && in_hs && (in_len != calc_len)) begin
      $display("rr_trace_packer: length disagreement in_len=%0d calc_len=%0d", in_len, calc_len);
    end
  end
`endif
`else
  assign eff_len = in_len;
  assign len_err = 1'b0;
`endif

  assign unit_masked = in_data & ~({FULL_WIDTH{1'b1}} << eff_len);

  // Drain first, then append, so a simultaneous unit lands right behind the retained bits.
  always_comb begin
    acc_base  = acc_q;
    fill_base = fill_q;
    if (out_hs) begin
      acc_base  = acc_q >> OUT_WIDTH;
      fill_base = (fill_q > OUT_W_F) ? (fill_q - OUT_W_F) : '0;
    end
    acc_d  = acc_base;
    fill_d = fill_base;
    if (in_hs) begin
      acc_d  = acc_base | (ACC_W'(unit_masked) << fill_base);
      fill_d = fill_base + FILL_WIDTH'(eff_len);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (flush) state_d = (fill_d == '0) ? S_DONE : S_FLUSH;
      end
      S_FLUSH: begin
        if ((fill_q == '0) || (out_hs && out_last)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q    <= S_RUN;
      acc_q      <= '0;
      fill_q     <= '0;
      unit_cnt_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      unit_cnt_q <= unit_cnt_q + CNT_WIDTH'(in_hs);
      beat_cnt_q <= beat_cnt_q + CNT_WIDTH'(out_hs);
    end
  end

endmodule

// File: tb/tb_rr_trace_packer.sv
// Randomized scoreboard bench for rr_trace_packer; the reference keeps a plain bit queue.
module tb_rr_trace_packer;
  localparam int FW = 303;
  localparam int OW = 512;
  localparam int LW = 9;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          sync_rst;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] in_data;
  logic [LW-1:0] in_len;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          flush_done;
  logic [CW-1:0] unit_cnt;
  logic [CW-1:0] beat_cnt;
  logic          len_err;

  rr_trace_packer dut (
    .clk        (clk),
    .sync_rst   (sync_rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_len     (in_len),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .flush_done (flush_done),
    .unit_cnt   (unit_cnt),
    .beat_cnt   (beat_cnt),
    .len_err    (len_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int rdy_mode = 1;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int          total = 0;
  int          bad = 0;
  logic [OW:0] exp_q[$];
  bit          bq[$];
  int          exp_units = 0;
  int          exp_beats = 0;
  int          exp_flushes = 0;
  int          fd_seen = 0;
  logic        exp_len_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push_beat(input logic last);
    logic [OW-1:0] v;
    bit            b;
    v = '0;
    for (int i = 0; i < OW; i++) begin
      b = 1'b0;
      if (bq.size() > 0) b = bq.pop_front();
      v = {b, v[OW-1:1]};
    end
    exp_q.push_back({last, v});
    exp_beats++;
  endtask

  task automatic model_accept(input logic [FW-1:0] d, input int len);
    int            eff;
    logic [FW-1:0] tmp;
    eff = len;
`ifdef RR_PACKER_LEN_CHECK_EN
    begin
      int calc;
      calc = 3 + (d[0] ? 100 : 0) + (d[1] ? 200 : 0);
      if (len != calc) begin
        exp_len_err = 1'b1;
        eff = calc;
      end
    end
`endif
    tmp = d;
    for (int i = 0; i < eff; i++) begin
      bq.push_back(tmp[0]);
      tmp = tmp >> 1;
    end
    exp_units++;
    while (bq.size() >= OW) push_beat(1'b0);
  endtask

  task automatic model_flush();
    if (bq.size() > 0) push_beat(1'b1);
    exp_flushes++;
  endtask

  function automatic logic [FW-1:0] rand_unit(input logic [1:0] bm);
    logic [FW-1:0] v;
    v = '0;
    for (int i = 0; i < FW; i++) v = {1'($urandom_range(0, 1)), v[FW-1:1]};
    v[1:0] = bm;
    return v;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [OW:0] e;
    forever begin
      @(negedge clk);
      if (!sync_rst) begin
        if (flush_done) fd_seen++;
        if (out_valid && out_ready) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL beat_unexpected: got last=%b data=%h, expected no beat", out_last, out_data);
          end else begin
            e = exp_q.pop_front();
            if ({out_last, out_data} !== e) begin
              bad++;
              $display("FAIL beat: got last=%b data=%h, expected last=%b data=%h",
                       out_last, out_data, e[OW], e[OW-1:0]);
            end
          end
        end
      end
    end
  end

  // ---------------- driver tasks (entered and left just after a rising edge) ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_unit(input logic [FW-1:0] d, input int len);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = LW'(len);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 64'(in_ready), 64'(1));
    if (in_ready) model_accept(d, len);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_wait", 64'(exp_q.size()), 64'(0));
    step();
  endtask

  task automatic do_flush();
    int n;
    wait_drain();
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    n = 0;
    @(negedge clk);
    while (!flush_done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("flush_done_wait", 64'(flush_done), 64'(1));
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [FW-1:0] d;
    logic [OW-1:0] head;
    logic [1:0]    bm;
    int            calc;
    int            len;

    sync_rst = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_len   = '0;
    flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sync_rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_last", 64'(out_last), 64'(0));
    check("rst_flush_done", 64'(flush_done), 64'(0));
    check("rst_unit_cnt", 64'(unit_cnt), 64'(0));
    check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
    check("rst_len_err", 64'(len_err), 64'(0));
    step();

    // two full units then a flush of the 94-bit remainder
    rdy_mode = 1;
    send_unit(rand_unit(2'b11), 303);
    send_unit(rand_unit(2'b11), 303);
    wait_drain();
    check("pair_unit_cnt", 64'(unit_cnt), 64'(exp_units));
    check("pair_beat_cnt", 64'(beat_cnt), 64'(exp_beats));
    do_flush();
    @(negedge clk);
    check("flush_beat_cnt", 64'(beat_cnt), 64'(exp_beats));
    check("flush_done_count", 64'(fd_seen), 64'(exp_flushes));
    check("flush_in_ready", 64'(in_ready), 64'(1));
    check("flush_done_width", 64'(flush_done), 64'(0));
    step();

    // backpressure with 606 buffered bits
    rdy_mode = 0;
    step();
    step();
    send_unit(rand_unit(2'b11), 303);
    send_unit(rand_unit(2'b11), 303);
    head = (exp_q.size() > 0) ? exp_q[0][OW-1:0] : '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_out_last", 64'(out_last), 64'(0));
      check("bp_data_hold", 64'(out_data == head), 64'(1));
    end
    step();
    rdy_mode = 1;
    wait_drain();
    @(negedge clk);
    check("bp_after_in_ready", 64'(in_ready), 64'(1));
    step();
    do_flush();

    // flush with nothing buffered
    flush = 1'b1;
    model_flush();
    step();
    flush = 1'b0;
    @(negedge clk);
    check("empty_flush_done", 64'(flush_done), 64'(1));
    check("empty_flush_valid", 64'(out_valid), 64'(0));
    @(negedge clk);
    check("empty_flush_done_drop", 64'(flush_done), 64'(0));
    check("empty_flush_valid2", 64'(out_valid), 64'(0));
    check("empty_flush_count", 64'(fd_seen), 64'(exp_flushes));
    step();

    // bitmap 01 with a short in_len
    send_unit(rand_unit(2'b01), 50);
    @(negedge clk);
    check("len_err_short", 64'(len_err), 64'(exp_len_err));
    step();
    do_flush();

    // randomized traffic with random downstream stalls and occasional flushes
    rdy_mode = 2;
    for (int u = 0; u < 250; u++) begin
      bm   = 2'($urandom_range(0, 3));
      d    = rand_unit(bm);
      calc = 3 + (bm[0] ? 100 : 0) + (bm[1] ? 200 : 0);
      len  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FW)) : calc;
      send_unit(d, len);
      if ($urandom_range(0, 24) == 0) do_flush();
    end
    do_flush();
    wait_drain();
    @(negedge clk);
    check("rand_unit_cnt", 64'(unit_cnt), 64'(exp_units));
    check("rand_beat_cnt", 64'(beat_cnt), 64'(exp_beats));
    check("rand_len_err", 64'(len_err), 64'(exp_len_err));
    check("rand_flush_count", 64'(fd_seen), 64'(exp_flushes));
    step();

    // reset while a final beat is stalled mid-flush
    rdy_mode = 0;
    step();
    step();
    send_unit(rand_unit(2'b11), 303);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("midflush_valid", 64'(out_valid), 64'(1));
    check("midflush_last", 64'(out_last), 64'(1));
    check("midflush_in_ready", 64'(in_ready), 64'(0));
    step();
    sync_rst = 1'b1;
    step();
    step();
    sync_rst = 1'b0;
    exp_q.delete();
    bq.delete();
    exp_units   = 0;
    exp_beats   = 0;
    exp_len_err = 1'b0;
    @(negedge clk);
    check("rst2_out_valid", 64'(out_valid), 64'(0));
    check("rst2_in_ready", 64'(in_ready), 64'(1));
    check("rst2_unit_cnt", 64'(unit_cnt), 64'(exp_units));
    check("rst2_beat_cnt", 64'(beat_cnt), 64'(exp_beats));
    check("rst2_len_err", 64'(len_err), 64'(exp_len_err));
    check("rst2_flush_done", 64'(flush_done), 64'(0));
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
